// File: rtl/best_hit_selector.sv
`timescale 1ns/1ps
// best_hit_selector
// Reduces each group of NUM_BLOCKS per-(pixel, block) intersection results to the
// single nearest visible hit (minimum t) and emits one record per pixel, one cycle
// after the group's last sample. A result is accepted every cycle; there is no
// backpressure, and valid_in gaps inside a group simply hold state.
// Optional build macro BEST_HIT_SEQ_CHECK_EN: a pixel change mid-group drops the
// partial group and restarts on the offending sample; pixel or block-index framing
// errors pulse seq_error_out one cycle later. Without it seq_error_out is tied low.
module best_hit_selector #(
    parameter int NUM_BLOCKS = 14,
    parameter int CNT_W      = 4
) (
    input  logic        clk_in,
    input  logic        rstn_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic [31:0] ray_in_x,
    input  logic [31:0] ray_in_y,
    input  logic [31:0] ray_in_z,
    input  logic [3:0]  block_index_in,
    input  logic        intersect_in,
    input  logic [31:0] t_in,
    input  logic        valid_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [31:0] ray_out_x,
    output logic [31:0] ray_out_y,
    output logic [31:0] ray_out_z,
    output logic        hit_out,
    output logic [3:0]  block_index_out,
    output logic [31:0] t_out,
    output logic        valid_out,
    output logic        seq_error_out
);

    localparam logic [31:0]      T_INF    = 32'h7F80_0000;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BLOCKS - 1);

    // group accumulation state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [31:0]      rx_q, rx_d;
    logic [31:0]      ry_q, ry_d;
    logic [31:0]      rz_q, rz_d;
    logic             best_hit_q, best_hit_d;
    logic [3:0]       best_idx_q, best_idx_d;
    logic [31:0]      best_t_q, best_t_d;

    // registered output record
    logic [10:0]      x_out_q;
    logic [9:0]       y_out_q;
    logic [31:0]      rx_out_q, ry_out_q, rz_out_q;
    logic             hit_out_q;
    logic [3:0]       idx_out_q;
    logic [31:0]      t_out_q;
    logic             valid_out_q;

    logic             t_is_nan;
    logic             cand;
    logic             pix_mismatch;
    logic [CNT_W-1:0] eff_cnt;
    logic             first;
    logic             last;
    logic             better;

    // A sample qualifies only if it hits with a non-negative, non-NaN distance;
    // that makes the unsigned compare on t[30:0] order-preserving.
    always_comb begin
        t_is_nan = (t_in[30:23] == 8'hFF) && (t_in[22:0] != 23'd0);
        cand     = intersect_in && !t_in[31] && !t_is_nan;
    end

`ifdef BEST_HIT_SEQ_CHECK_EN
    assign pix_mismatch = valid_in && (cnt_q != '0) && ((x_in != x_q) || (y_in != y_q));
`else
    assign pix_mismatch = 1'b0;
`endif

    // A pixel change restarts the group, so the offending sample acts as slot 0.
    assign eff_cnt = pix_mismatch ? '0 : cnt_q;
    assign first   = (eff_cnt == '0);
    assign last    = (eff_cnt == CNT_LAST);
    assign better  = cand && (!best_hit_q || (t_in[30:0] < best_t_q[30:0]));

    // Next-state for the running minimum; ties keep the earlier sample.
    always_comb begin
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        rx_d       = rx_q;
        ry_d       = ry_q;
        rz_d       = rz_q;
        best_hit_d = best_hit_q;
        best_idx_d = best_idx_q;
        best_t_d   = best_t_q;
        if (valid_in) begin
            if (first) begin
                x_d        = x_in;
                y_d        = y_in;
                rx_d       = ray_in_x;
                ry_d       = ray_in_y;
                rz_d       = ray_in_z;
                best_hit_d = cand;
                best_idx_d = block_index_in;
                best_t_d   = cand ? t_in : T_INF;
            end else if (better) begin
                best_hit_d = 1'b1;
                best_idx_d = block_index_in;
                best_t_d   = t_in;
            end
            cnt_d = last ? '0 : eff_cnt + 1'b1;
        end
    end

    // Group state registers; reset discards any partial group.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            rx_q       <= '0;
            ry_q       <= '0;
            rz_q       <= '0;
            best_hit_q <= 1'b0;
            best_idx_q <= '0;
            best_t_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            rz_q       <= rz_d;
            best_hit_q <= best_hit_d;
            best_idx_q <= best_idx_d;
            best_t_q   <= best_t_d;
        end
    end

    // Output record loads from the final best (including the last sample) and holds
    // until the next completed group; a miss reports index 0 and +inf.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            x_out_q     <= '0;
            y_out_q     <= '0;
            rx_out_q    <= '0;
            ry_out_q    <= '0;
            rz_out_q    <= '0;
            hit_out_q   <= 1'b0;
            idx_out_q   <= '0;
            t_out_q     <= '0;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= valid_in && last;
            if (valid_in && last) begin
                x_out_q   <= x_d;
                y_out_q   <= y_d;
                rx_out_q  <= rx_d;
                ry_out_q  <= ry_d;
                rz_out_q  <= rz_d;
                hit_out_q <= best_hit_d;
                idx_out_q <= best_hit_d ? best_idx_d : 4'd0;
                t_out_q   <= best_hit_d ? best_t_d : T_INF;
            end
        end
    end

`ifdef BEST_HIT_SEQ_CHECK_EN
    logic seq_err_q;

    // Framing error pulse: pixel change mid-group or block index out of sequence.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= valid_in &&
                         (pix_mismatch || (32'(block_index_in) != 32'(eff_cnt)));
        end
    end

    assign seq_error_out = seq_err_q;
`else
    assign seq_error_out = 1'b0;
`endif

    assign x_out           = x_out_q;
    assign y_out           = y_out_q;
    assign ray_out_x       = rx_out_q;
    assign ray_out_y       = ry_out_q;
    assign ray_out_z       = rz_out_q;
    assign hit_out         = hit_out_q;
    assign block_index_out = idx_out_q;
    assign t_out           = t_out_q;
    assign valid_out       = valid_out_q;

endmodule

// File: tb/tb_best_hit_selector.sv
`timescale 1ns/1ps
// Testbench for best_hit_selector: directed vector table, back-to-back and gapped
// groups, randomized groups against a group-level reference model, async reset
// mid-group, and (when BEST_HIT_SEQ_CHECK_EN is defined) framing-error cases.
module tb_best_hit_selector;

    localparam int NB = 14;

    logic        clk_in = 1'b0;
    logic        rstn_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic [31:0] ray_in_x, ray_in_y, ray_in_z;
    logic [3:0]  block_index_in;
    logic        intersect_in;
    logic [31:0] t_in;
    logic        valid_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic [31:0] ray_out_x, ray_out_y, ray_out_z;
    logic        hit_out;
    logic [3:0]  block_index_out;
    logic [31:0] t_out;
    logic        valid_out;
    logic        seq_error_out;

    best_hit_selector dut (
        .clk_in(clk_in), .rstn_in(rstn_in),
        .x_in(x_in), .y_in(y_in),
        .ray_in_x(ray_in_x), .ray_in_y(ray_in_y), .ray_in_z(ray_in_z),
        .block_index_in(block_index_in), .intersect_in(intersect_in),
        .t_in(t_in), .valid_in(valid_in),
        .x_out(x_out), .y_out(y_out),
        .ray_out_x(ray_out_x), .ray_out_y(ray_out_y), .ray_out_z(ray_out_z),
        .hit_out(hit_out), .block_index_out(block_index_out), .t_out(t_out),
        .valid_out(valid_out), .seq_error_out(seq_error_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [31:0] rx, ry, rz;
        logic [3:0]  idx;
        logic        inter;
        logic [31:0] t;
    } smp_t;

    typedef struct {
        logic [153:0] rec;
        longint       due;
    } exp_t;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        int          ia, ib, ic;
        logic [31:0] ta, tb_v, tc;
        logic        e_hit;
        logic [3:0]  e_idx;
        logic [31:0] e_t;
    } vec_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           pulses  = 0;
    smp_t         grp[$];
    exp_t         expq[$];
    longint       seq_q[$];
    logic [153:0] seen[$];

    function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic bit is_cand(input smp_t s);
        return s.inter && !s.t[31] && !((s.t[30:23] == 8'hFF) && (s.t[22:0] != 23'd0));
    endfunction

    // Reference: nearest candidate over the whole collected group; earliest on ties.
    function automatic logic [153:0] reduce_group();
        bit          any = 0;
        bit          found = 0;
        logic [30:0] m = '1;
        logic        hit;
        logic [3:0]  idx = 4'd0;
        logic [31:0] t = 32'h7F80_0000;
        foreach (grp[i]) begin
            if (is_cand(grp[i]) && (!any || grp[i].t[30:0] < m)) m = grp[i].t[30:0];
            if (is_cand(grp[i])) any = 1;
        end
        hit = any;
        if (any) begin
            foreach (grp[i]) begin
                if (!found && is_cand(grp[i]) && grp[i].t[30:0] == m) begin
                    idx = grp[i].idx;
                    t = {1'b0, m};
                    found = 1;
                end
            end
        end
        return {grp[0].x, grp[0].y, grp[0].rx, grp[0].ry, grp[0].rz, hit, idx, t};
    endfunction

    function automatic void model_step(input smp_t s, input longint tc);
        exp_t e;
`ifdef BEST_HIT_SEQ_CHECK_EN
        bit err = 0;
        if (grp.size() != 0 && (s.x != grp[0].x || s.y != grp[0].y)) begin
            grp.delete();
            err = 1;
        end
        if (int'(s.idx) != grp.size()) err = 1;
        if (err) seq_q.push_back(tc);
`endif
        grp.push_back(s);
        if (grp.size() == NB) begin
            e.rec = reduce_group();
            e.due = tc;
            expq.push_back(e);
            grp.delete();
        end
    endfunction

    // Output monitor: every pulse must match the next expected record on its due edge.
    always @(negedge clk_in) begin
        longint       edge_t;
        logic         exp_v;
        logic         exp_s;
        logic [153:0] act;
        edge_t = $time - 5;
        if (rstn_in) begin
            act = {x_out, y_out, ray_out_x, ray_out_y, ray_out_z, hit_out, block_index_out, t_out};
            exp_v = (expq.size() > 0) && (expq[0].due == edge_t);
            if (valid_out || exp_v) begin
                chk("valid_out timing", {159'd0, valid_out}, {159'd0, exp_v});
                if (valid_out && exp_v) chk("output record", {6'd0, act}, {6'd0, expq[0].rec});
                if (exp_v) void'(expq.pop_front());
            end
            if (valid_out) begin
                pulses++;
                seen.push_back(act);
            end
            exp_s = (seq_q.size() > 0) && (seq_q[0] == edge_t);
            if (seq_error_out || exp_s) begin
                chk("seq_error_out", {159'd0, seq_error_out}, {159'd0, exp_s});
                if (exp_s) void'(seq_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send(input smp_t s);
        x_in = s.x;  y_in = s.y;
        ray_in_x = s.rx;  ray_in_y = s.ry;  ray_in_z = s.rz;
        block_index_in = s.idx;  intersect_in = s.inter;  t_in = s.t;
        valid_in = 1'b1;
        @(posedge clk_in);
        model_step(s, $time);
        #1;
        valid_in = 1'b0;
        intersect_in = 1'b1;
        t_in = 32'h0000_0001;
        block_index_in = 4'hF;
        x_in = 11'h7FF;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    function automatic vec_t mkv(input logic [10:0] x, input logic [9:0] y,
                                 input int ia, input logic [31:0] ta,
                                 input int ib, input logic [31:0] tb_v,
                                 input int ic, input logic [31:0] tc,
                                 input logic eh, input logic [3:0] ei, input logic [31:0] et);
        vec_t v;
        v.x = x; v.y = y; v.ia = ia; v.ta = ta; v.ib = ib; v.tb_v = tb_v; v.ic = ic; v.tc = tc;
        v.e_hit = eh; v.e_idx = ei; v.e_t = et;
        return v;
    endfunction

    function automatic smp_t plain(input logic [10:0] x, input logic [9:0] y, input int i,
                                   input logic [31:0] rx, input logic [31:0] ry, input logic [31:0] rz);
        smp_t s;
        s.x = x; s.y = y; s.rx = rx; s.ry = ry; s.rz = rz;
        s.idx = 4'(i); s.inter = 1'b0; s.t = $urandom;
        return s;
    endfunction

    function automatic logic [31:0] rand_t();
        logic [31:0] pool [4];
        pool[0] = 32'h3F80_0000; pool[1] = 32'h4000_0000; pool[2] = 32'h0000_0000; pool[3] = 32'h3F00_0000;
        case ($urandom_range(0, 5))
            0: return pool[$urandom_range(0, 3)];
            1: return {1'b0, 31'($urandom)};
            2: return {1'b1, 31'($urandom)};
            3: return {1'b0, 8'hFF, 23'($urandom_range(1, 8388607))};
            4: return 32'h7F80_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    vec_t vecs[8];
    smp_t ga[NB];
    smp_t gb[NB];

    initial begin
        smp_t        s;
        int          p0;
        logic [31:0] rx, ry, rz;

        vecs[0] = mkv(11'd5,    10'd7,    3, 32'h4040_0000, -1, 0, -1, 0, 1'b1, 4'd3,  32'h4040_0000);
        vecs[1] = mkv(11'd8,    10'd9,    2, 32'h40A0_0000, 9, 32'h4000_0000, 11, 32'hBF80_0000, 1'b1, 4'd9, 32'h4000_0000);
        vecs[2] = mkv(11'd1,    10'd2,   -1, 0, -1, 0, -1, 0, 1'b0, 4'd0, 32'h7F80_0000);
        vecs[3] = mkv(11'd3,    10'd3,    4, 32'h3F80_0000, 6, 32'h3F80_0000, -1, 0, 1'b1, 4'd4, 32'h3F80_0000);
        vecs[4] = mkv(11'd100,  10'd200,  0, 32'h7FC0_0000, 12, 32'h4100_0000, 5, 32'h8000_0000, 1'b1, 4'd12, 32'h4100_0000);
        vecs[5] = mkv(11'd2047, 10'd1023, 13, 32'h3F00_0000, 0, 32'h4000_0000, -1, 0, 1'b1, 4'd13, 32'h3F00_0000);
        vecs[6] = mkv(11'd0,    10'd0,    7, 32'h7F80_0000, 8, 32'hFF80_0000, -1, 0, 1'b1, 4'd7, 32'h7F80_0000);
        vecs[7] = mkv(11'd9,    10'd9,    3, 32'hBF80_0000, -1, 0, -1, 0, 1'b0, 4'd0, 32'h7F80_0000);

        rstn_in = 1'b0; valid_in = 1'b0; intersect_in = 1'b0; t_in = '0;
        x_in = '0; y_in = '0; ray_in_x = '0; ray_in_y = '0; ray_in_z = '0; block_index_in = '0;
        repeat (2) @(negedge clk_in);
        chk("reset valid_out", {159'd0, valid_out}, 160'd0);
        chk("reset seq_error_out", {159'd0, seq_error_out}, 160'd0);
        chk("reset record", {6'd0, x_out, y_out, ray_out_x, ray_out_y, ray_out_z, hit_out, block_index_out, t_out}, 160'd0);
        @(posedge clk_in);
        #1;
        rstn_in = 1'b1;

        // directed table
        for (int v = 0; v < 8; v++) begin
            rx = $urandom; ry = $urandom; rz = $urandom;
            for (int i = 0; i < NB; i++) begin
                s = plain(vecs[v].x, vecs[v].y, i, rx, ry, rz);
                if (i == vecs[v].ia) begin s.inter = 1'b1; s.t = vecs[v].ta; end
                if (i == vecs[v].ib) begin s.inter = 1'b1; s.t = vecs[v].tb_v; end
                if (i == vecs[v].ic) begin s.inter = 1'b1; s.t = vecs[v].tc; end
                send(s);
            end
            @(negedge clk_in);
            chk("vec valid_out", {159'd0, valid_out}, 160'd1);
            chk("vec hit_out", {159'd0, hit_out}, {159'd0, vecs[v].e_hit});
            chk("vec block_index_out", {156'd0, block_index_out}, {156'd0, vecs[v].e_idx});
            chk("vec t_out", {128'd0, t_out}, {128'd0, vecs[v].e_t});
            chk("vec pixel", {139'd0, x_out, y_out}, {139'd0, vecs[v].x, vecs[v].y});
            chk("vec ray", {64'd0, ray_out_x, ray_out_y, ray_out_z}, {64'd0, rx, ry, rz});
        end
        @(negedge clk_in);
        chk("valid_out one-cycle pulse", {159'd0, valid_out}, 160'd0);
        chk("data hold after pulse", {128'd0, t_out}, {128'd0, vecs[7].e_t});

        // back-to-back groups, then same groups with 3-cycle gaps
        rx = $urandom; ry = $urandom; rz = $urandom;
        for (int i = 0; i < NB; i++) begin
            ga[i] = plain(11'd40, 10'd41, i, rx, ry, rz);
            ga[i].inter = ($urandom_range(0, 1) == 1); ga[i].t = rand_t();
            gb[i] = plain(11'd42, 10'd43, i, ry, rz, rx);
            gb[i].inter = ($urandom_range(0, 1) == 1); gb[i].t = rand_t();
        end
        seen.delete();
        p0 = pulses;
        for (int i = 0; i < NB; i++) send(ga[i]);
        for (int i = 0; i < NB; i++) send(gb[i]);
        idle(2);
        chk("b2b pulse count", 160'(pulses - p0), 160'd2);
        p0 = pulses;
        for (int i = 0; i < NB; i++) begin send(ga[i]); idle(3); end
        for (int i = 0; i < NB; i++) begin send(gb[i]); idle(3); end
        idle(2);
        chk("gapped pulse count", 160'(pulses - p0), 160'd2);
        if (seen.size() == 4) begin
            chk("gapped vs b2b group A", {6'd0, seen[2]}, {6'd0, seen[0]});
            chk("gapped vs b2b group B", {6'd0, seen[3]}, {6'd0, seen[1]});
        end else begin
            chk("captured pulse records", 160'(seen.size()), 160'd4);
        end

        // randomized groups against the reference model
        for (int g = 0; g < 40; g++) begin
            logic [10:0] px;
            logic [9:0]  py;
            px = 11'($urandom_range(0, 2047));
            py = 10'($urandom_range(0, 1023));
            rx = $urandom; ry = $urandom; rz = $urandom;
            for (int i = 0; i < NB; i++) begin
                s = plain(px, py, i, rx, ry, rz);
                s.inter = ($urandom_range(0, 2) == 0);
                s.t = rand_t();
                send(s);
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(2);

        // async reset mid-group, then a fresh full group
        rx = $urandom; ry = $urandom; rz = $urandom;
        for (int i = 0; i < 6; i++) begin
            s = plain(11'd77, 10'd66, i, rx, ry, rz);
            s.inter = 1'b1; s.t = 32'h3F80_0000;
            send(s);
        end
        #2;
        rstn_in = 1'b0;
        grp.delete(); expq.delete(); seq_q.delete();
        @(negedge clk_in);
        chk("mid-group reset valid_out", {159'd0, valid_out}, 160'd0);
        chk("mid-group reset record", {6'd0, x_out, y_out, ray_out_x, ray_out_y, ray_out_z, hit_out, block_index_out, t_out}, 160'd0);
        @(posedge clk_in);
        #1;
        rstn_in = 1'b1;
        p0 = pulses;
        for (int i = 0; i < NB; i++) begin
            s = plain(11'd78, 10'd67, i, rx, ry, rz);
            s.inter = (i == 10); s.t = (i == 10) ? 32'h4080_0000 : $urandom;
            send(s);
            if (i == NB - 2) chk("no pulse before fresh group completes", 160'(pulses - p0), 160'd0);
        end
        @(negedge clk_in);
        chk("fresh group pulse", {159'd0, valid_out}, 160'd1);
        chk("fresh group result", {124'd0, block_index_out, t_out}, {124'd0, 4'd10, 32'h4080_0000});

`ifdef BEST_HIT_SEQ_CHECK_EN
        // pixel change mid-group drops the partial group
        idle(2);
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            s = plain(11'd1, 10'd1, i, rx, ry, rz);
            s.inter = 1'b1; s.t = 32'h3F00_0000;
            send(s);
        end
        for (int i = 0; i < NB; i++) begin
            s = plain(11'd2, 10'd1, i, rx, ry, rz);
            s.inter = (i == 8); s.t = 32'h4000_0000;
            send(s);
        end
        idle(2);
        chk("seq drop pulse count", 160'(pulses - p0), 160'd1);
        chk("seq drop pixel", {139'd0, x_out, y_out}, {139'd0, 11'd2, 10'd1});
        chk("seq drop result", {124'd0, block_index_out, t_out}, {124'd0, 4'd8, 32'h4000_0000});
        // out-of-sequence block index still accumulates
        p0 = pulses;
        for (int i = 0; i < NB; i++) begin
            s = plain(11'd4, 10'd4, i, rx, ry, rz);
            if (i == 5) begin s.idx = 4'd7; s.inter = 1'b1; s.t = 32'h3E00_0000; end
            send(s);
        end
        idle(2);
        chk("index error pulse count", 160'(pulses - p0), 160'd1);
        chk("index error result", {124'd0, block_index_out, t_out}, {124'd0, 4'd7, 32'h3E00_0000});
`endif

        idle(2);
        chk("expected outputs drained", 160'(expq.size()), 160'd0);
        chk("expected seq errors drained", 160'(seq_q.size()), 160'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/best_hit_selector.md
Name: best_hit_selector

Overview:
- Receiver end of the per-(pixel, block) intersection result stream produced by the ray/block intersection pipeline.
- Upstream issues NUM_BLOCKS consecutive results for the same pixel, one per block index. This block reduces each group to the single nearest visible hit (minimum t).
- Emits one record per pixel to the shader/pixel writer.
- Upstream has no backpressure, so this block must accept a result every cycle.

Parameters:
- NUM_BLOCKS, 14: results per pixel group, block indices 0..NUM_BLOCKS-1; index 13 is the saber.
- CNT_W, 4: width of the group counter; must satisfy 2^CNT_W >= NUM_BLOCKS.

Ports:
- clk_in  input  1  system clock
- rstn_in  input  1  reset, asynchronous, active-low
- x_in  input  11  pixel x of the incoming result
- y_in  input  10  pixel y of the incoming result
- ray_in_x  input  32  ray direction x, IEEE-754 single
- ray_in_y  input  32  ray direction y, IEEE-754 single
- ray_in_z  input  32  ray direction z, IEEE-754 single
- block_index_in  input  4  block index of this result
- intersect_in  input  1  ray hits the block and the block is visible
- t_in  input  32  hit distance, IEEE-754 single
- valid_in  input  1  result present this cycle
- x_out  output  11  pixel x of the group
- y_out  output  10  pixel y of the group
- ray_out_x  output  32  ray of the group, x
- ray_out_y  output  32  ray of the group, y
- ray_out_z  output  32  ray of the group, z
- hit_out  output  1  at least one block in the group was hit
- block_index_out  output  4  index of the nearest hit block
- t_out  output  32  t of the nearest hit
- valid_out  output  1  one-cycle pulse per completed group
- seq_error_out  output  1  one-cycle pulse on a group framing error

Behaviour:
- Reset: clock is clk_in; reset rstn_in is asynchronous and active-low. While rstn_in=0, all outputs are 0, the group counter is 0 and internal best state is cleared. Reset mid-group discards the partial group.
- Candidate: a sample is a candidate iff intersect_in=1 and t_in[31]=0. Negative or -0 t is never a hit. NaN t (exponent all ones with nonzero mantissa) is never a hit.
- Comparison: distances are compared as unsigned integers on t[30:0]. This is valid because all candidates are non-negative. No floating-point IP is used.
- Group counter cnt runs 0..NUM_BLOCKS-1 and advances only on valid_in=1. Cycles with valid_in=0 hold all state; gaps inside a group are legal.
- First sample (cnt=0):
  - Latch x, y and ray into the group registers.
  - best_hit = candidate; best_idx = block_index_in; best_t = t_in.
  - If the sample is not a candidate, best_t = 32'h7F800000 (+inf).
- Later samples: update best only if the sample is a candidate and (best_hit=0 or t_in[30:0] < best_t[30:0]). Ties keep the earlier sample.
- Last sample (cnt=NUM_BLOCKS-1):
  - The final best includes this sample.
  - Next cycle: valid_out=1 and all outputs are loaded; cnt returns to 0.
  - Latency is 1 cycle from the last valid_in to valid_out.
- When hit_out=0: block_index_out=0 and t_out=32'h7F800000.
- Data outputs hold their value until the next valid_out.
- A new group may start on the cycle immediately after a group's last sample, with no bubble. Sustained throughput is 1 result/cycle.
- valid_out and seq_error_out are deasserted every cycle in which they are not pulsed.
- NUM_BLOCKS=1: every valid sample completes a group.

Optional Feature:
- Macro: BEST_HIT_SEQ_CHECK_EN.
- Defined:
  - When valid_in=1, cnt!=0 and (x_in,y_in) differs from the latched pixel, the partial group is dropped with no valid_out.
  - seq_error_out pulses 1 cycle later.
  - The offending sample is treated as cnt=0 of a new group.
  - block_index_in != cnt on any sample also pulses seq_error_out; the sample is still accumulated normally.
- Undefined: no checks are made, pixel is taken from the first sample of each group, and seq_error_out is tied to 0.

Test Plan:
- Reset, then NUM_BLOCKS=14 samples for pixel (5,7), only index 3 hit with t=0x40400000 (3.0) -> one valid_out; hit_out=1, block_index_out=3, t_out=0x40400000, x_out=5, y_out=7.
- Group with hits at idx 2 (t=0x40A00000) and idx 9 (t=0x40000000), plus intersect_in=1 at idx 11 with t=0xBF800000 (-1.0) -> block_index_out=9, t_out=0x40000000.
- Group with no intersect_in asserted -> hit_out=0, block_index_out=0, t_out=0x7F800000.
- Tie: idx 4 and idx 6 both at t=0x3F800000 -> block_index_out=4.
- Two groups back-to-back with no gap, plus a second run with 3-cycle valid_in gaps inside the group -> exactly two valid_out pulses per run, each 1 cycle after that group's 14th sample; results identical between the two runs.
- With BEST_HIT_SEQ_CHECK_EN: after 5 samples of (1,1), a sample for (2,1) arrives, followed by 13 more for (2,1) -> seq_error_out pulse, no output for (1,1), then valid_out for (2,1).
- Async reset asserted mid-group, samples then resent from idx 0 -> no valid_out during or after reset until 14 fresh samples complete.
